// File: rtl/scan_bist_engine.sv
// Logic-BIST engine: LFSR-generated scan loads and PI patterns for one CUT, MISR compaction of
// scan_out and primary outputs, and a golden-signature compare at the end of each run.
module scan_bist_engine #(
  parameter int unsigned           CHAIN_LEN  = 9,
  parameter int unsigned           PI_WIDTH   = 7,
  parameter int unsigned           PO_WIDTH   = 9,
  parameter int unsigned           N_PATTERNS = 256,
  parameter int unsigned           LFSR_WIDTH = 16,
  parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS  = 16'hB400,
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED  = 16'h0001,
  parameter int unsigned           MISR_WIDTH = 16,
  parameter logic [MISR_WIDTH-1:0] MISR_TAPS  = 16'hB400,
  parameter logic [MISR_WIDTH-1:0] GOLDEN_SIG = 16'h0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bist_start,
  input  logic                  scan_out,
  input  logic [PO_WIDTH-1:0]   cut_po,
  output logic                  scan_en,
  output logic                  scan_in,
  output logic [PI_WIDTH-1:0]   cut_pi,
  output logic                  running,
  output logic                  bist_end,
  output logic                  pass_nfail,
  output logic [MISR_WIDTH-1:0] signature
);

  localparam int unsigned ScW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int unsigned PcW = $clog2(N_PATTERNS + 1);
  localparam logic [ScW-1:0] ShiftLast = ScW'(CHAIN_LEN - 1);
  localparam logic [PcW-1:0] PatLast   = PcW'(N_PATTERNS - 1);
  // An all-zero seed would lock the LFSR up.
  localparam logic [LFSR_WIDTH-1:0] SeedEff =
      (LFSR_SEED == '0) ? LFSR_WIDTH'(1) : LFSR_SEED;

  typedef enum logic [2:0] {StIdle, StInit, StShift, StCapture, StFlush, StDone} state_e;

  state_e                  state_q, state_d;
  logic                    prev_start_q;
  logic [ScW-1:0]          shift_cnt_q, shift_cnt_d;
  logic [PcW-1:0]          pattern_cnt_q, pattern_cnt_d;
  logic [LFSR_WIDTH-1:0]   lfsr_q, lfsr_d;
  logic [MISR_WIDTH-1:0]   misr_q, misr_d;
  logic                    scan_en_q, scan_in_q, running_q, bist_end_q, pass_nfail_q;
  logic [PI_WIDTH-1:0]     cut_pi_q;
  logic                    start_pulse;

  function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] v);
    return {1'b0, v[LFSR_WIDTH-1:1]} ^ (v[0] ? LFSR_TAPS : '0);
  endfunction

  function automatic logic [MISR_WIDTH-1:0] misr_step(input logic [MISR_WIDTH-1:0] m,
                                                      input logic [MISR_WIDTH-1:0] d);
    return {m[MISR_WIDTH-2:0], 1'b0} ^ (m[MISR_WIDTH-1] ? MISR_TAPS : '0) ^ d;
  endfunction

  assign start_pulse = bist_start & ~prev_start_q;

  always_comb begin
    state_d       = state_q;
    shift_cnt_d   = shift_cnt_q;
    pattern_cnt_d = pattern_cnt_q;
    lfsr_d        = lfsr_q;
    misr_d        = misr_q;
    unique case (state_q)
      StIdle: if (start_pulse) state_d = StInit;
      StInit: begin
        lfsr_d        = SeedEff;
        misr_d        = '0;
        pattern_cnt_d = '0;
        shift_cnt_d   = '0;
        state_d       = StShift;
      end
      StShift: begin
        lfsr_d = lfsr_step(lfsr_q);
        // Chain contents are unknown until the first pattern has been loaded.
        if (pattern_cnt_q != '0) misr_d = misr_step(misr_q, MISR_WIDTH'(scan_out));
        if (shift_cnt_q == ShiftLast) begin
          shift_cnt_d = '0;
          state_d     = StCapture;
        end else begin
          shift_cnt_d = shift_cnt_q + ScW'(1);
        end
      end
      StCapture: begin
        lfsr_d        = lfsr_step(lfsr_q);
        misr_d        = misr_step(misr_q, MISR_WIDTH'(cut_po));
        pattern_cnt_d = pattern_cnt_q + PcW'(1);
        state_d       = (pattern_cnt_q == PatLast) ? StFlush : StShift;
      end
      StFlush: begin
        misr_d = misr_step(misr_q, MISR_WIDTH'(scan_out));
        if (shift_cnt_q == ShiftLast) begin
          shift_cnt_d = '0;
          state_d     = StDone;
        end else begin
          shift_cnt_d = shift_cnt_q + ScW'(1);
        end
      end
      StDone: if (!bist_start) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      prev_start_q  <= 1'b0;
      shift_cnt_q   <= '0;
      pattern_cnt_q <= '0;
      lfsr_q        <= SeedEff;
      misr_q        <= '0;
      scan_en_q     <= 1'b0;
      scan_in_q     <= 1'b0;
      cut_pi_q      <= '0;
      running_q     <= 1'b0;
      bist_end_q    <= 1'b0;
      pass_nfail_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_start_q  <= bist_start;
      shift_cnt_q   <= shift_cnt_d;
      pattern_cnt_q <= pattern_cnt_d;
      lfsr_q        <= lfsr_d;
      misr_q        <= misr_d;
      scan_en_q     <= (state_d == StShift) || (state_d == StFlush);
      scan_in_q     <= (state_d == StShift) & lfsr_d[0];
      if (state_d == StCapture) cut_pi_q <= lfsr_d[PI_WIDTH-1:0];
      running_q     <= state_d inside {StInit, StShift, StCapture, StFlush};
      bist_end_q    <= (state_d == StDone);
      pass_nfail_q  <= (state_d == StDone) && (misr_d == GOLDEN_SIG);
    end
  end

  assign scan_en    = scan_en_q;
  assign scan_in    = scan_in_q;
  assign cut_pi     = cut_pi_q;
  assign running    = running_q;
  assign bist_end   = bist_end_q;
  assign pass_nfail = pass_nfail_q;
  assign signature  = misr_q;

endmodule

// File: doc/scan_bist_engine.md
Name: scan_bist_engine

Overview:
- Parametrised logic-BIST engine for one scan-inserted circuit under test (CUT).
- Generates pseudo-random scan-load and primary-input patterns from an internal LFSR, drives scan_en/scan_in, and compacts scan_out plus CUT primary outputs into a MISR.
- At end of run it compares the signature against a golden value and reports bist_end / pass_nfail.
- Sits in the top level between the BIST start pin and the CUT.

Parameters:
- CHAIN_LEN, 9, scan flip-flops in the CUT chain (shift cycles per pattern), >=1
- PI_WIDTH, 7, CUT primary inputs driven from LFSR bits [PI_WIDTH-1:0], <= LFSR_WIDTH
- PO_WIDTH, 9, CUT primary outputs compacted at capture, <= MISR_WIDTH
- N_PATTERNS, 256, patterns applied per run, >=1
- LFSR_WIDTH, 16, pattern LFSR width
- LFSR_TAPS, 16'hB400, Galois feedback mask of the pattern LFSR
- LFSR_SEED, 16'h0001, LFSR value loaded at INIT; an all-zero value is replaced by 1
- MISR_WIDTH, 16, signature register width
- MISR_TAPS, 16'hB400, MISR feedback mask
- GOLDEN_SIG, 16'h0000, expected final signature

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- bist_start  in  1  run request; a run starts on its rising edge
- scan_out  in  1  serial output of the CUT chain
- cut_po  in  PO_WIDTH  CUT primary outputs
- scan_en  out  1  1 = CUT chain shifts, 0 = functional capture
- scan_in  out  1  serial data into the CUT chain
- cut_pi  out  PI_WIDTH  CUT primary-input pattern
- running  out  1  high from INIT through FLUSH
- bist_end  out  1  high while in DONE
- pass_nfail  out  1  1 = signature matched; valid while bist_end=1
- signature  out  MISR_WIDTH  current MISR contents

Behaviour:
- Reset (reset=0): state=IDLE, all counters=0, LFSR=seed, MISR=0, prev_start=0.
- Reset outputs: scan_en=0, scan_in=0, cut_pi=0, running=0, bist_end=0, pass_nfail=0.
- Start detect: prev_start is a registered copy of bist_start. start_pulse = bist_start & ~prev_start. A start_pulse is acted on only in IDLE.
- FSM states and transitions:
  - IDLE: waits for start_pulse, then goes to INIT.
  - INIT (1 cycle): LFSR<=seed, MISR<=0, pattern_cnt<=0, shift_cnt<=0; next state SHIFT.
  - SHIFT: scan_en=1, scan_in=LFSR[0]; the LFSR advances every cycle. After CHAIN_LEN cycles (shift_cnt reaches CHAIN_LEN-1), go to CAPTURE.
  - CAPTURE (1 cycle): scan_en=0, cut_pi=LFSR[PI_WIDTH-1:0]; MISR absorbs cut_po; the LFSR advances. pattern_cnt increments.
    - If pattern_cnt was N_PATTERNS-1, go to FLUSH; otherwise go to SHIFT.
  - FLUSH: CHAIN_LEN shift cycles with scan_en=1 and scan_in=0 to unload the last response, then go to DONE.
  - DONE: bist_end=1 and pass_nfail=(MISR==GOLDEN_SIG), both registered on entry. Stays in DONE while bist_start=1; goes to IDLE when bist_start=0.
- cut_pi is registered and holds its last value outside CAPTURE.
- MISR update: next = {misr[W-2:0],0} ^ (misr[W-1] ? MISR_TAPS : 0) ^ d.
  - SHIFT: d = scan_out in bit 0. The MISR updates during SHIFT only when pattern_cnt>=1, so the first pattern's load never compacts unknown chain contents.
  - FLUSH: d = scan_out in bit 0, MISR updates every cycle.
  - CAPTURE: d = zero-extended cut_po.
- LFSR update: next = {0,lfsr[W-1:1]} ^ (lfsr[0] ? LFSR_TAPS : 0).
- Cycle count: a run lasts exactly 1 + N_PATTERNS*(CHAIN_LEN+1) + CHAIN_LEN cycles from INIT entry to DONE entry.
- Boundary conditions:
  - bist_start falling mid-run does not abort the run; only reset aborts.
  - start_pulse outside IDLE is ignored.
  - A new run requires bist_start to go low and then high again.
  - Asserting reset mid-run returns the block to IDLE with all outputs at their reset values.
  - With CHAIN_LEN=1, SHIFT and FLUSH each last a single cycle.
- signature output is the live MISR value and is frozen in DONE.

Test Plan:
- Reset: hold reset=0 for 3 cycles with random inputs -> all outputs 0, signature=0.
- Basic run: CHAIN_LEN=4, N_PATTERNS=3, hold bist_start=1 -> bist_end rises exactly 1+3*5+4=20 cycles after the first INIT cycle. scan_en sequence is 1111 0 1111 0 1111 0 1111. running=1 throughout.
- Signature match: scan_out tied to 0 and cut_po=0 -> signature=0. With GOLDEN_SIG=0, pass_nfail=1; with GOLDEN_SIG=16'h0001, pass_nfail=0.
- Fault detect: on the default configuration, compute the golden value from a reference-model CUT, then force one scan cell stuck-at-1 in the CUT -> pass_nfail=0, bist_end=1.
- Handshake: drop bist_start at cycle 10 of a run -> the run completes and the block enters DONE then IDLE. Raise bist_start again -> a second run yields an identical signature.
- Mid-run reset: assert reset=0 during FLUSH -> outputs are 0 immediately (asynchronous). A subsequent start yields the same signature as an uninterrupted run.
